// File: rtl/eeprom_ctrl.sv
// eeprom_ctrl: sequences an I2C master through EEPROM page writes and random
// reads. Writes send a 16-bit memory address followed by up to 16 bytes from an
// internal write buffer, then wait out the EEPROM internal write time. Reads
// send the address, issue a repeated start in read mode and return each byte
// on rd_data/rd_valid.
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only when idle)
//   cmd_rw, cmd_mem_addr,      0 = write / 1 = read, EEPROM address,
//   cmd_len                    byte count (0 -> 1, >16 -> 16)
//   wbuf_we, wbuf_data         push a byte into the 16-entry write buffer
//   rd_data, rd_valid          read byte with 1-cycle qualifier
//   busy, done                 not idle / 1-cycle completion pulse
//   i2c_*                      command outputs to and handshakes from the I2C master
module eeprom_ctrl #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         TWR_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [15:0] cmd_mem_addr,
  input  logic [4:0] cmd_len,
  input  logic       wbuf_we,
  input  logic [7:0] wbuf_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       i2c_start,
  output logic [7:0] i2c_nbytes,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_write_data,
  input  logic       i2c_tx_data_req,
  input  logic       i2c_rx_data_ready,
  input  logic [7:0] i2c_read_data
);

  typedef enum logic [2:0] {
    IDLE, WR_XFER, RD_ADDR, RD_XFER, DRAIN, WR_WAIT, DONE
  } state_t;

  localparam int CNT_W = (TWR_CYCLES > 12) ? $clog2(TWR_CYCLES + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic             tx_q, rx_q;
  logic             tx_edge, rx_edge;
  logic [4:0]       e, e_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       len, len_nxt;
  logic             rw, rw_nxt;
  logic [15:0]      addr, addr_nxt;
  logic [4:0]       wptr, wptr_nxt;
  logic [7:0]       wbuf [16];
  logic             push;
  logic [4:0]       len_eff;
  logic [4:0]       widx;
  logic [7:0]       tx_byte;

  logic       start_nxt, i2c_rw_nxt, rd_valid_nxt, done_nxt;
  logic [7:0] nbytes_nxt, wdata_nxt, rd_data_nxt;
  logic [6:0] i2c_addr_nxt;

  assign tx_edge   = i2c_tx_data_req & ~tx_q;
  assign rx_edge   = i2c_rx_data_ready & ~rx_q;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign push      = (state == IDLE) && wbuf_we && (wptr != 5'd16);

  assign len_eff = (cmd_len == 5'd0) ? 5'd1 :
                   (cmd_len > 5'd16) ? 5'd16 : cmd_len;

  // Byte sent for edge index e. Buffer slots never written for this command
  // read as zero, so a short buffer pads with 8'h00.
  always_comb begin
    tx_byte = 8'h00;
    widx    = e - 5'd2;
    if (e == 5'd0)
      tx_byte = addr[15:8];
    else if (e == 5'd1)
      tx_byte = addr[7:0];
    else if ((e <= len + 5'd1) && (widx < wptr))
      tx_byte = wbuf[widx[3:0]];
  end

  always_comb begin
    state_nxt    = state;
    e_nxt        = e;
    cnt_nxt      = cnt;
    len_nxt      = len;
    rw_nxt       = rw;
    addr_nxt     = addr;
    wptr_nxt     = wptr;
    start_nxt    = i2c_start;
    i2c_rw_nxt   = i2c_rw;
    nbytes_nxt   = i2c_nbytes;
    i2c_addr_nxt = i2c_addr;
    wdata_nxt    = i2c_write_data;
    rd_data_nxt  = rd_data;
    rd_valid_nxt = 1'b0;
    done_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (push) wptr_nxt = wptr + 5'd1;
        if (cmd_valid) begin
          addr_nxt     = cmd_mem_addr;
          rw_nxt       = cmd_rw;
          len_nxt      = len_eff;
          e_nxt        = 5'd0;
          i2c_addr_nxt = DEV_ADDR;
          i2c_rw_nxt   = 1'b0;
          start_nxt    = 1'b1;
          if (cmd_rw) begin
            nbytes_nxt = 8'd2;
            state_nxt  = RD_ADDR;
          end else begin
            nbytes_nxt = {3'b000, len_eff} + 8'd2;
            state_nxt  = WR_XFER;
          end
        end
      end

      WR_XFER: begin
        if (tx_edge) begin
          wdata_nxt = tx_byte;
          e_nxt     = e + 5'd1;
          if (e == 5'd0) start_nxt = 1'b0;
          // The master requests one more byte than it sends; that extra
          // request marks the end of the write.
          if ({1'b0, e} == {1'b0, len} + 6'd2) begin
            cnt_nxt   = CNT_W'(12);
            state_nxt = DRAIN;
          end
        end
      end

      RD_ADDR: begin
        if (cnt != '0) begin
          // Holding i2c_start high while rw flips makes the master issue a
          // repeated start once the address phase drains.
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            start_nxt = 1'b0;
            e_nxt     = 5'd0;
            state_nxt = RD_XFER;
          end
        end else if (tx_edge) begin
          wdata_nxt = tx_byte;
          e_nxt     = e + 5'd1;
          if (e == 5'd2) begin
            i2c_rw_nxt = 1'b1;
            nbytes_nxt = {3'b000, len};
            cnt_nxt    = CNT_W'(12);
          end
        end
      end

      RD_XFER: begin
        if (rx_edge) begin
          rd_data_nxt  = i2c_read_data;
          rd_valid_nxt = 1'b1;
          e_nxt        = e + 5'd1;
          if (e + 5'd1 == len) begin
            cnt_nxt   = CNT_W'(4);
            state_nxt = DRAIN;
          end
        end
      end

      DRAIN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt <= CNT_ONE) begin
          if (rw) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = CNT_W'(TWR_CYCLES);
            state_nxt = WR_WAIT;
          end
        end
      end

      WR_WAIT: begin
        if (cnt <= CNT_ONE) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      DONE: begin
        done_nxt  = 1'b1;
        wptr_nxt  = 5'd0;
        e_nxt     = 5'd0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      tx_q           <= 1'b0;
      rx_q           <= 1'b0;
      e              <= 5'd0;
      cnt            <= '0;
      len            <= 5'd0;
      rw             <= 1'b0;
      addr           <= 16'h0000;
      wptr           <= 5'd0;
      i2c_start      <= 1'b0;
      i2c_rw         <= 1'b0;
      i2c_nbytes     <= 8'd0;
      i2c_addr       <= DEV_ADDR;
      i2c_write_data <= 8'h00;
      rd_data        <= 8'h00;
      rd_valid       <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      tx_q           <= i2c_tx_data_req;
      rx_q           <= i2c_rx_data_ready;
      e              <= e_nxt;
      cnt            <= cnt_nxt;
      len            <= len_nxt;
      rw             <= rw_nxt;
      addr           <= addr_nxt;
      wptr           <= wptr_nxt;
      i2c_start      <= start_nxt;
      i2c_rw         <= i2c_rw_nxt;
      i2c_nbytes     <= nbytes_nxt;
      i2c_addr       <= i2c_addr_nxt;
      i2c_write_data <= wdata_nxt;
      rd_data        <= rd_data_nxt;
      rd_valid       <= rd_valid_nxt;
      done           <= done_nxt;
    end
  end

  // NOTE: the buffer storage has no reset; entries at or beyond wptr are
  // never read, so clearing the pointer is enough to empty it.
  always_ff @(posedge clk) begin
    if (push) wbuf[wptr[3:0]] <= wbuf_data;
  end

endmodule

// File: tb/tb_eeprom_ctrl.sv
module tb_eeprom_ctrl;

  localparam int TWR = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [15:0] cmd_mem_addr;
  logic [4:0]  cmd_len;
  logic        wbuf_we;
  logic [7:0]  wbuf_data;
  logic [7:0]  rd_data;
  logic        rd_valid, busy, done;
  logic        i2c_start, i2c_rw;
  logic [7:0]  i2c_nbytes, i2c_write_data, i2c_read_data;
  logic [6:0]  i2c_addr;
  logic        i2c_tx_data_req, i2c_rx_data_ready;

  int n_vec  = 0;
  int n_miss = 0;
  int rv_cnt = 0;
  int done_cnt = 0;

  eeprom_ctrl #(.DEV_ADDR(7'h50), .TWR_CYCLES(TWR)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_mem_addr(cmd_mem_addr), .cmd_len(cmd_len),
    .wbuf_we(wbuf_we), .wbuf_data(wbuf_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .i2c_start(i2c_start), .i2c_nbytes(i2c_nbytes), .i2c_addr(i2c_addr),
    .i2c_rw(i2c_rw), .i2c_write_data(i2c_write_data),
    .i2c_tx_data_req(i2c_tx_data_req), .i2c_rx_data_ready(i2c_rx_data_ready),
    .i2c_read_data(i2c_read_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_valid) rv_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wbuf_we = 1'b1; wbuf_data = d;
    tick;
    wbuf_we = 1'b0;
  endtask

  task automatic issue(input logic rw, input logic [15:0] a, input logic [4:0] len);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_mem_addr = a; cmd_len = len;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic tx_pulse(output logic [7:0] d);
    i2c_tx_data_req = 1'b1;
    tick;
    d = i2c_write_data;
    i2c_tx_data_req = 1'b0;
    tick;
  endtask

  task automatic rx_pulse(input logic [7:0] v);
    i2c_read_data = v; i2c_rx_data_ready = 1'b1;
    tick;
    check("rd_valid_hi", rd_valid, 1'b1);
    check("rd_data", rd_data, v);
    i2c_rx_data_ready = 1'b0;
    tick;
    check("rd_valid_lo", rd_valid, 1'b0);
  endtask

  // Waits for the return to idle; done must pulse in exactly that cycle.
  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (busy && cyc < budget) begin
      tick;
      cyc++;
    end
    check("idle_reached", busy, 1'b0);
    check("done_pulse", done, 1'b1);
    check("ready_at_done", cmd_ready, 1'b1);
  endtask

  task automatic rd_addr_phase(input logic [15:0] a, input logic [7:0] n_exp);
    logic [7:0] d;
    int w;
    tx_pulse(d); check("rd_addr_hi", d, a[15:8]);
    tx_pulse(d); check("rd_addr_lo", d, a[7:0]);
    tx_pulse(d);
    check("rs_rw", i2c_rw, 1'b1);
    check("rs_nbytes", i2c_nbytes, n_exp);
    check("rs_start_held", i2c_start, 1'b1);
    w = 0;
    while (i2c_start && w < 40) begin
      tick;
      w++;
    end
    check("rs_start_drop", i2c_start, 1'b0);
  endtask

  task automatic check_reset_state;
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_start", i2c_start, 1'b0);
    check("rst_rw", i2c_rw, 1'b0);
    check("rst_nbytes", i2c_nbytes, 8'd0);
    check("rst_addr", i2c_addr, 7'h50);
    check("rst_wdata", i2c_write_data, 8'h00);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_valid", rd_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    int cyc, rv0, dn0;
    logic [7:0] exp_wr [5];

    reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_mem_addr = 16'h0;
    cmd_len = 5'd0; wbuf_we = 1'b0; wbuf_data = 8'h0;
    i2c_tx_data_req = 1'b0; i2c_rx_data_ready = 1'b0; i2c_read_data = 8'h0;
    repeat (3) tick;
    check_reset_state();
    reset = 1'b1;
    tick;

    // Two-byte write to 0x0123.
    push(8'hA5);
    push(8'h5A);
    issue(1'b0, 16'h0123, 5'd2);
    check("wr_busy", busy, 1'b1);
    check("wr_ready", cmd_ready, 1'b0);
    check("wr_start", i2c_start, 1'b1);
    check("wr_nbytes", i2c_nbytes, 8'd4);
    check("wr_rw", i2c_rw, 1'b0);
    check("wr_addr", i2c_addr, 7'h50);
    exp_wr = '{8'h01, 8'h23, 8'hA5, 8'h5A, 8'h00};
    for (int i = 0; i < 5; i++) begin
      tx_pulse(d);
      check($sformatf("wr_byte%0d", i), d, exp_wr[i]);
      if (i == 0) check("wr_start_drop", i2c_start, 1'b0);
    end
    wait_idle(200, cyc);
    check("wr_twr_wait", (cyc >= TWR + 10) && (cyc <= TWR + 14), 1'b1);
    tick;
    check("done_one_cycle", done, 1'b0);

    // Three-byte read from 0x00FF with a stale-high rx_data_ready.
    i2c_rx_data_ready = 1'b1;
    rv0 = rv_cnt;
    issue(1'b1, 16'h00FF, 5'd3);
    check("rd_start", i2c_start, 1'b1);
    check("rd_nbytes_addr", i2c_nbytes, 8'd2);
    check("rd_rw_addr", i2c_rw, 1'b0);
    rd_addr_phase(16'h00FF, 8'd3);
    i2c_rx_data_ready = 1'b0;
    tick;
    check("stale_rx_no_valid", rv_cnt - rv0, 0);
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    rx_pulse(8'h33);
    wait_idle(50, cyc);
    check("rd_valid_count", rv_cnt - rv0, 3);
    tick;

    // Seventeen pushes; the last is dropped. len=20 clamps to 16.
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
    issue(1'b0, 16'hABCD, 5'd20);
    check("full_nbytes", i2c_nbytes, 8'd18);
    tx_pulse(d); check("full_addr_hi", d, 8'hAB);
    tx_pulse(d); check("full_addr_lo", d, 8'hCD);
    for (int i = 0; i < 16; i++) begin
      tx_pulse(d);
      check($sformatf("full_byte%0d", i), d, 8'h10 + 8'(i));
    end
    tx_pulse(d);
    wait_idle(200, cyc);
    tick;

    // Short buffer, push and command while busy are both ignored.
    push(8'h77);
    issue(1'b0, 16'h0200, 5'd3);
    push(8'hEE);
    check("busy_nbytes", i2c_nbytes, 8'd5);
    exp_wr = '{8'h02, 8'h00, 8'h77, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      tx_pulse(d);
      check($sformatf("short_byte%0d", i), d, exp_wr[i]);
    end
    tx_pulse(d);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_mem_addr = 16'h3333; cmd_len = 5'd1;
    repeat (10) tick;
    check("busy_ready_low", cmd_ready, 1'b0);
    check("busy_no_reload_rw", i2c_rw, 1'b0);
    check("busy_no_reload_n", i2c_nbytes, 8'd5);
    cmd_valid = 1'b0;
    wait_idle(200, cyc);
    tick;
    check("busy_no_second_start", i2c_start, 1'b0);
    check("busy_no_second_busy", busy, 1'b0);

    // Reset during RD_XFER.
    issue(1'b1, 16'h0040, 5'd2);
    rd_addr_phase(16'h0040, 8'd2);
    rx_pulse(8'h99);
    dn0 = done_cnt;
    reset = 1'b0;
    tick;
    check_reset_state();
    reset = 1'b1;
    repeat (6) tick;
    check("rst_no_done", done_cnt - dn0, 0);
    check("rst_idle_ready", cmd_ready, 1'b1);

    // cmd_len=0 read behaves as a single-byte read.
    rv0 = rv_cnt;
    issue(1'b1, 16'h0007, 5'd0);
    check("len0_accepted", busy, 1'b1);
    rd_addr_phase(16'h0007, 8'd1);
    rx_pulse(8'h5C);
    i2c_rx_data_ready = 1'b1;
    tick;
    i2c_rx_data_ready = 1'b0;
    tick;
    wait_idle(50, cyc);
    tick;
    check("len0_one_valid", rv_cnt - rv0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
